// File: rtl/lsd_pkg.sv
// Shared LSD types: ceil-log2 helper, readout FSM states and the segment record.
// Reused by the buffer, the segment reader and the overlay stages.
package lsd_pkg;

    localparam int LSD_COORD_W = 16;

    typedef logic [LSD_COORD_W-1:0] lsd_coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } lsd_state_t;

    typedef struct packed {
        lsd_coord_t start_v;
        lsd_coord_t start_h;
        lsd_coord_t end_v;
        lsd_coord_t end_h;
    } lsd_seg_t;

    // Ceiling log2; evaluated at elaboration to size coordinate and address fields.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsd_seg_len_filter.sv
// Manhattan length of one segment compared against MIN_LEN.
// keep=1 means the segment is long enough to be emitted.
module lsd_seg_len_filter
    import lsd_pkg::*;
#(
    parameter int V_BITW  = 9,
    parameter int H_BITW  = 10,
    parameter int MIN_LEN = 8
) (
    input  logic [V_BITW-1:0] start_v,
    input  logic [H_BITW-1:0] start_h,
    input  logic [V_BITW-1:0] end_v,
    input  logic [H_BITW-1:0] end_h,
    output logic              keep
);

    localparam int D_W = ((V_BITW > H_BITW) ? V_BITW : H_BITW) + 1;

    logic [D_W-1:0] sv_x, sh_x, ev_x, eh_x;
    logic [D_W-1:0] dv, dh;
    logic [D_W:0]   len;

    always_comb begin
        sv_x = D_W'(start_v);
        sh_x = D_W'(start_h);
        ev_x = D_W'(end_v);
        eh_x = D_W'(end_h);
        dv   = (ev_x >= sv_x) ? (ev_x - sv_x) : (sv_x - ev_x);
        dh   = (eh_x >= sh_x) ? (eh_x - sh_x) : (sh_x - eh_x);
        len  = {1'b0, dv} + {1'b0, dh};
        keep = (len >= (D_W + 1)'(MIN_LEN));
    end

endmodule

// File: rtl/lsd_segment_reader.sv
// Reads one completed frame of line segments out of the LSD buffer onto a valid/ready stream.
// Optional length filter compiled in with LSD_READER_LEN_FILTER_EN.
module lsd_segment_reader
    import lsd_pkg::*;
#(
    parameter int FRAME_HEIGHT = 480,
    parameter int FRAME_WIDTH  = 640,
    parameter int RAM_SIZE     = 4096,
    parameter int MIN_LEN      = 8,
    localparam int V_BITW      = log2(FRAME_HEIGHT),
    localparam int H_BITW      = log2(FRAME_WIDTH),
    localparam int ADDR_BITW   = log2(RAM_SIZE),
    localparam int WORD_SIZE   = 2 * (H_BITW + V_BITW)
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 in_ready,
    input  logic [ADDR_BITW:0]   in_line_num,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic [ADDR_BITW-1:0] out_rd_addr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [V_BITW-1:0]    m_start_v,
    output logic [H_BITW-1:0]    m_start_h,
    output logic [V_BITW-1:0]    m_end_v,
    output logic [H_BITW-1:0]    m_end_h,
    output logic                 out_busy,
    output logic                 out_done,
    output logic [ADDR_BITW:0]   out_count,
    output logic                 out_overrun
);

    lsd_state_t state_q, state_d;

    logic                 rd_ready_q;
    logic [ADDR_BITW:0]   num_q, num_d;
    logic [ADDR_BITW-1:0] addr_q, addr_d;
    logic                 m_valid_q, m_valid_d;
    logic [V_BITW-1:0]    start_v_q, start_v_d, end_v_q, end_v_d;
    logic [H_BITW-1:0]    start_h_q, start_h_d, end_h_q, end_h_d;
    logic [ADDR_BITW:0]   count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic                 done_q, done_d;

    logic [V_BITW-1:0] rd_start_v, rd_end_v;
    logic [H_BITW-1:0] rd_start_h, rd_end_h;
    logic              start;
    logic              last;
    logic              keep;

    assign rd_end_h   = in_data[H_BITW-1:0];
    assign rd_end_v   = in_data[H_BITW+V_BITW-1:H_BITW];
    assign rd_start_h = in_data[2*H_BITW+V_BITW-1:H_BITW+V_BITW];
    assign rd_start_v = in_data[WORD_SIZE-1:2*H_BITW+V_BITW];

    // Rising edge of the frame-ready flag with a non-empty frame.
    assign start = in_ready && !rd_ready_q && (in_line_num != '0);
    assign last  = ({1'b0, addr_q} == (num_q - 1'b1));

`ifdef LSD_READER_LEN_FILTER_EN
    lsd_seg_len_filter #(
        .V_BITW  (V_BITW),
        .H_BITW  (H_BITW),
        .MIN_LEN (MIN_LEN)
    ) u_len_filter (
        .start_v (rd_start_v),
        .start_h (rd_start_h),
        .end_v   (rd_end_v),
        .end_h   (rd_end_h),
        .keep    (keep)
    );
`else
    assign keep = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (!in_ready)  state_d = DONE;
                else if (keep)  state_d = SEND;
                else if (last)  state_d = DONE;
            end
            SEND: begin
                // A pending beat is never withdrawn; an overrun only ends the frame after it is taken.
                if (m_ready) begin
                    state_d = (last || overrun_q || !in_ready) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        num_d     = num_q;
        addr_d    = addr_q;
        m_valid_d = m_valid_q;
        start_v_d = start_v_q;
        start_h_d = start_h_q;
        end_v_d   = end_v_q;
        end_h_d   = end_h_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        done_d    = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d     = in_line_num;
                    addr_d    = '0;
                    count_d   = '0;
                    overrun_d = 1'b0;
                end
            end
            FETCH: begin
                if (!in_ready) begin
                    overrun_d = 1'b1;
                end else if (keep) begin
                    start_v_d = rd_start_v;
                    start_h_d = rd_start_h;
                    end_v_d   = rd_end_v;
                    end_h_d   = rd_end_h;
                    m_valid_d = 1'b1;
                end else if (!last) begin
                    addr_d = addr_q + 1'b1;
                end
            end
            SEND: begin
                if (!in_ready) overrun_d = 1'b1;
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    count_d   = count_q + 1'b1;
                    if (!last) addr_d = addr_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            rd_ready_q <= 1'b0;
            num_q      <= '0;
            addr_q     <= '0;
            m_valid_q  <= 1'b0;
            start_v_q  <= '0;
            start_h_q  <= '0;
            end_v_q    <= '0;
            end_h_q    <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_ready_q <= in_ready;
            num_q      <= num_d;
            addr_q     <= addr_d;
            m_valid_q  <= m_valid_d;
            start_v_q  <= start_v_d;
            start_h_q  <= start_h_d;
            end_v_q    <= end_v_d;
            end_h_q    <= end_h_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            done_q     <= done_d;
        end
    end

    assign out_rd_addr = addr_q;
    assign m_valid     = m_valid_q;
    assign m_start_v   = start_v_q;
    assign m_start_h   = start_h_q;
    assign m_end_v     = end_v_q;
    assign m_end_h     = end_h_q;
    assign out_busy    = (state_q != IDLE);
    assign out_done    = done_q;
    assign out_count   = count_q;
    assign out_overrun = overrun_q;

endmodule

// File: tb/tb_lsd_segment_reader.sv
// Directed bench for lsd_segment_reader with a small combinational buffer model.
// The length-filter case is active only when LSD_READER_LEN_FILTER_EN is defined.
module tb_lsd_segment_reader;

    localparam int V_BITW    = 9;
    localparam int H_BITW    = 10;
    localparam int ADDR_BITW = 4;
    localparam int WORD_SIZE = 2 * (V_BITW + H_BITW);

    logic                 clock = 1'b0;
    logic                 rst;
    logic                 in_ready;
    logic [ADDR_BITW:0]   in_line_num;
    logic [WORD_SIZE-1:0] in_data;
    logic [ADDR_BITW-1:0] out_rd_addr;
    logic                 m_valid;
    logic                 m_ready;
    logic [V_BITW-1:0]    m_start_v, m_end_v;
    logic [H_BITW-1:0]    m_start_h, m_end_h;
    logic                 out_busy, out_done, out_overrun;
    logic [ADDR_BITW:0]   out_count;

    logic [WORD_SIZE-1:0] mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    lsd_segment_reader #(
        .FRAME_HEIGHT (480),
        .FRAME_WIDTH  (640),
        .RAM_SIZE     (16),
        .MIN_LEN      (8)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .in_ready    (in_ready),
        .in_line_num (in_line_num),
        .in_data     (in_data),
        .out_rd_addr (out_rd_addr),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_start_v   (m_start_v),
        .m_start_h   (m_start_h),
        .m_end_v     (m_end_v),
        .m_end_h     (m_end_h),
        .out_busy    (out_busy),
        .out_done    (out_done),
        .out_count   (out_count),
        .out_overrun (out_overrun)
    );

    always #5 clock = ~clock;

    assign in_data = mem[out_rd_addr];

    function automatic logic [WORD_SIZE-1:0] mk(input logic [8:0] sv, input logic [9:0] sh,
                                                input logic [8:0] ev, input logic [9:0] eh);
        return {sv, sh, ev, eh};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx);
        chk({tag, "_valid"}, 64'(m_valid), 64'd1);
        chk({tag, "_data"}, 64'({m_start_v, m_start_h, m_end_v, m_end_h}), 64'(mem[idx]));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_busy"}, 64'(out_busy), 64'd0);
        chk({tag, "_done"}, 64'(out_done), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst         = 1'b1;
        in_ready    = 1'b0;
        in_line_num = '0;
        m_ready     = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk_idle("reset");
        chk("reset_count", 64'(out_count), 64'd0);
        chk("reset_overrun", 64'(out_overrun), 64'd0);
        chk("reset_addr", 64'(out_rd_addr), 64'd0);

        // Frame 1: three segments, m_ready held high.
        mem[0] = mk(9'd10, 10'd20, 9'd30, 10'd40);
        mem[1] = mk(9'd479, 10'd639, 9'd0, 10'd1);
        mem[2] = mk(9'd123, 10'd456, 9'd78, 10'd9);
        in_line_num = 5'd3;
        m_ready     = 1'b1;
        in_ready    = 1'b1;
        step();
        chk("f1_fetch_busy", 64'(out_busy), 64'd1);
        chk("f1_fetch_valid", 64'(m_valid), 64'd0);
        chk("f1_fetch_addr", 64'(out_rd_addr), 64'd0);
        step(); chk_beat("f1_beat0", 0);
        step(); chk("f1_c2_valid", 64'(m_valid), 64'd0);
        chk("f1_c2_addr", 64'(out_rd_addr), 64'd1);
        chk("f1_c2_count", 64'(out_count), 64'd1);
        step(); chk_beat("f1_beat1", 1);
        step(); chk("f1_c4_addr", 64'(out_rd_addr), 64'd2);
        step(); chk_beat("f1_beat2", 2);
        step(); chk("f1_c6_done", 64'(out_done), 64'd0);
        chk("f1_c6_valid", 64'(m_valid), 64'd0);
        chk("f1_c6_count", 64'(out_count), 64'd3);
        step(); chk("f1_c7_done", 64'(out_done), 64'd1);
        chk("f1_c7_count", 64'(out_count), 64'd3);
        chk("f1_c7_busy", 64'(out_busy), 64'd0);
        step(); chk("f1_c8_done", 64'(out_done), 64'd0);
        // Held high after completion: no retrigger.
        step(); step();
        chk_idle("f1_hold");

        // Frame 2: stall 5 cycles on the second beat.
        in_ready = 1'b0;
        step();
        mem[0] = mk(9'd1, 10'd2, 9'd3, 10'd4);
        mem[1] = mk(9'd256, 10'd512, 9'd128, 10'd64);
        mem[2] = mk(9'd5, 10'd6, 9'd7, 10'd8);
        in_ready = 1'b1;
        step();
        step(); chk_beat("f2_beat0", 0);
        step(); m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_beat("f2_stall", 1);
            chk("f2_stall_count", 64'(out_count), 64'd1);
        end
        m_ready = 1'b1;
        step(); chk("f2_after_valid", 64'(m_valid), 64'd0);
        chk("f2_after_count", 64'(out_count), 64'd2);
        step(); chk_beat("f2_beat2", 2);
        step(); chk("f2_c_count", 64'(out_count), 64'd3);
        step(); chk("f2_done", 64'(out_done), 64'd1);

        // Empty frame: no readout, count untouched.
        in_ready = 1'b0;
        step();
        in_line_num = 5'd0;
        in_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("empty");
        end
        chk("empty_count", 64'(out_count), 64'd3);

        // Overrun: in_ready drops while the 2nd of 4 beats is pending.
        in_ready = 1'b0;
        step();
        mem[3] = mk(9'd99, 10'd99, 9'd99, 10'd99);
        in_line_num = 5'd4;
        in_ready    = 1'b1;
        step();
        step(); chk_beat("ov_beat0", 0);
        step(); m_ready = 1'b0;
        step(); chk_beat("ov_beat1", 1);
        in_ready = 1'b0;
        step(); chk_beat("ov_held", 1);
        chk("ov_flag_set", 64'(out_overrun), 64'd1);
        m_ready = 1'b1;
        step(); chk("ov_c_valid", 64'(m_valid), 64'd0);
        chk("ov_c_count", 64'(out_count), 64'd2);
        step(); chk("ov_done", 64'(out_done), 64'd1);
        chk("ov_count", 64'(out_count), 64'd2);
        chk("ov_sticky", 64'(out_overrun), 64'd1);
        step(); step();
        chk_idle("ov_after");
        chk("ov_still", 64'(out_overrun), 64'd1);

        // Next frame start clears overrun; single line.
        in_line_num = 5'd1;
        in_ready    = 1'b1;
        step(); chk("n1_overrun_clr", 64'(out_overrun), 64'd0);
        chk("n1_count_clr", 64'(out_count), 64'd0);
        step(); chk_beat("n1_beat0", 0);
        step(); step();
        chk("n1_done", 64'(out_done), 64'd1);
        chk("n1_count", 64'(out_count), 64'd1);
        in_line_num = 5'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("n1_noretrig");
        end
        in_ready = 1'b0;
        step();
        in_line_num = 5'd1;
        in_ready    = 1'b1;
        step();
        step(); chk_beat("n2_beat0", 0);
        step(); step();
        chk("n2_done", 64'(out_done), 64'd1);

        // Reset in the middle of a readout.
        in_ready = 1'b0;
        step();
        in_line_num = 5'd3;
        in_ready    = 1'b1;
        m_ready     = 1'b0;
        step();
        step(); chk_beat("rst_beat", 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst_mid");
        chk("rst_mid_count", 64'(out_count), 64'd0);
        step();
        chk("rst_mid_done", 64'(out_done), 64'd0);
        m_ready = 1'b1;

`ifdef LSD_READER_LEN_FILTER_EN
        // Lengths 3, 10, 5: only the middle segment survives MIN_LEN=8.
        in_ready = 1'b0;
        step();
        mem[0] = mk(9'd10, 10'd10, 9'd11, 10'd12);
        mem[1] = mk(9'd100, 10'd200, 9'd96, 10'd206);
        mem[2] = mk(9'd50, 10'd60, 9'd52, 10'd57);
        in_line_num = 5'd3;
        in_ready    = 1'b1;
        step(); chk("flt_c0_valid", 64'(m_valid), 64'd0);
        step(); chk("flt_c1_valid", 64'(m_valid), 64'd0);
        chk("flt_c1_addr", 64'(out_rd_addr), 64'd1);
        step(); chk_beat("flt_beat", 1);
        step(); chk("flt_c3_valid", 64'(m_valid), 64'd0);
        step(); chk("flt_c4_valid", 64'(m_valid), 64'd0);
        step(); chk("flt_done", 64'(out_done), 64'd1);
        chk("flt_count", 64'(out_count), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
